// File: rtl/cksum_fill_pkg.sv
// Shared definitions for the checksum fill controller and its engine.
// Contents:
//   - bus widths and the halfword byte-select constants
//   - state encodings for the controller FSM and the checksum engine FSM
//   - ones_add(): 16-bit one's-complement addition with end-around carry
package cksum_fill_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Byte enables for a halfword inside a 32-bit word. The halfword at
    // address%4 == 0 is carried in data[31:16]; at address%4 == 2 it is
    // carried in data[15:0].
    localparam logic [3:0] SEL_HI = 4'b1100;
    localparam logic [3:0] SEL_LO = 4'b0011;

    typedef enum logic [2:0] {
        FILL_IDLE,
        FILL_CLEAR,
        FILL_KICK,
        FILL_WAIT,
        FILL_WRITE,
        FILL_DONE
    } fill_state_t;

    typedef enum logic [1:0] {
        ENG_IDLE,
        ENG_RUN,
        ENG_DONE
    } eng_state_t;

    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        // Folding the carry back in cannot overflow again (max 0xFFFE + 1).
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/cksum_fill_if.sv
// SRAM master port bundle.
//   sram_ce_o    chip enable
//   sram_we_o    write enable
//   sram_addr_o  byte address
//   sram_sel_o   byte enables (bit 3 = data[31:24] = lowest byte address)
//   sram_data_o  write data
//   sram_data_i  read data, valid one cycle after the address
// master: the controller side; slave: the memory side.
interface cksum_fill_if;
    import cksum_fill_pkg::*;

    logic              sram_ce_o;
    logic              sram_we_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [3:0]        sram_sel_o;
    logic [DATA_W-1:0] sram_data_o;
    logic [DATA_W-1:0] sram_data_i;

    modport master (
        output sram_ce_o, sram_we_o, sram_addr_o, sram_sel_o, sram_data_o,
        input  sram_data_i
    );

    modport slave (
        input  sram_ce_o, sram_we_o, sram_addr_o, sram_sel_o, sram_data_o,
        output sram_data_i
    );

endinterface

// File: rtl/cksum_fill_cksum.sv
// Checksum engine: reads i_len bytes starting at i_addr as 16-bit halfwords
// and returns the one's complement of their one's-complement sum.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_start         level request; the engine returns to idle only after it drops
//   i_addr, i_len   even start address, even nonzero byte length
//   o_ready         result valid; stays high until the next run is accepted
//   o_cksum         16-bit result
//   o_sram_*        read-only SRAM master port
//   i_sram_data     SRAM read data, one cycle after the address
module cksum_fill_cksum
    import cksum_fill_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_len,
    output logic              o_ready,
    output logic [15:0]       o_cksum,
    output logic              o_sram_ce,
    output logic              o_sram_we,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [3:0]        o_sram_sel,
    output logic [DATA_W-1:0] o_sram_data,
    input  logic [DATA_W-1:0] i_sram_data
);

    eng_state_t        r_state;
    eng_state_t        w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_cnt;       // halfwords still to be issued
    logic              r_pend_v;    // a read was issued last cycle
    logic              r_pend_hi;   // that read targets data[31:16]
    logic [15:0]       r_sum;
    logic              r_ready;
    logic [15:0]       r_result;
    logic              w_issue;
    logic [15:0]       w_half;

    assign w_issue = (r_state == ENG_RUN) && (r_cnt != 32'd0);
    assign w_half  = r_pend_hi ? i_sram_data[31:16] : i_sram_data[15:0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ENG_IDLE: if (i_start) w_state_next = ENG_RUN;
            ENG_RUN:  if (r_cnt == 32'd0 && !r_pend_v) w_state_next = ENG_DONE;
            ENG_DONE: if (!i_start) w_state_next = ENG_IDLE;
            default:  w_state_next = ENG_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ENG_IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_pend_v  <= 1'b0;
            r_pend_hi <= 1'b0;
            r_sum     <= '0;
            r_ready   <= 1'b0;
            r_result  <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ENG_IDLE: begin
                    if (i_start) begin
                        r_addr   <= i_addr;
                        r_cnt    <= i_len >> 1;
                        r_sum    <= '0;
                        r_pend_v <= 1'b0;
                        r_ready  <= 1'b0;
                    end
                end
                ENG_RUN: begin
                    // One halfword issued per cycle; its data is folded in
                    // the following cycle.
                    r_pend_v  <= w_issue;
                    r_pend_hi <= ~r_addr[1];
                    if (w_issue) begin
                        r_addr <= r_addr + 32'd2;
                        r_cnt  <= r_cnt - 32'd1;
                    end
                    if (r_pend_v) r_sum <= ones_add(r_sum, w_half);
                    if (w_state_next == ENG_DONE) begin
                        r_ready  <= 1'b1;
                        r_result <= ~r_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ready     = r_ready;
    assign o_cksum     = r_result;
    assign o_sram_ce   = w_issue;
    assign o_sram_we   = 1'b0;
    assign o_sram_addr = r_addr & ~32'd3;
    assign o_sram_sel  = 4'b1111;
    assign o_sram_data = '0;

endmodule

// File: rtl/cksum_fill.sv
// Checksum fill controller. Generate mode zeroes the header's checksum
// field, runs the engine over the header and writes the result into the
// field. Verify mode runs the engine and reports whether the result is 0.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   start_i       level request, held until done_o, then dropped
//   mode_i        0 = generate, 1 = verify (sampled with start_i in IDLE)
//   hdr_addr_i    header byte address (even)
//   hdr_len_i     header length in bytes (even, nonzero)
//   cks_off_i     checksum field offset inside the header (even)
//   sram          SRAM master port, shared between this block and the engine
//   done_o        finished; held until start_i drops
//   err_o         bad arguments (valid with done_o)
//   ok_o          verify result valid (valid with done_o)
//   cksum_o       engine result (held after the run)
module cksum_fill
    import cksum_fill_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [ADDR_W-1:0] hdr_addr_i,
    input  logic [31:0]       hdr_len_i,
    input  logic [31:0]       cks_off_i,
    cksum_fill_if.master      sram,
    output logic              done_o,
    output logic              err_o,
    output logic              ok_o,
    output logic [15:0]       cksum_o
);

    fill_state_t       r_state;
    fill_state_t       w_state_next;
    logic              r_mode;
    logic [ADDR_W-1:0] r_hdr_addr;
    logic [31:0]       r_hdr_len;
    logic [ADDR_W-1:0] r_field_addr;
    logic              r_done;
    logic              r_err;
    logic              r_ok;
    logic [15:0]       r_cksum;

    logic              w_arg_err;
    logic [ADDR_W-1:0] w_field_word;
    logic [3:0]        w_field_sel;

    logic              w_eng_start;
    logic              w_eng_ready;
    logic [15:0]       w_eng_cksum;
    logic              w_eng_ce;
    logic              w_eng_we;
    logic [ADDR_W-1:0] w_eng_addr;
    logic [3:0]        w_eng_sel;
    logic [DATA_W-1:0] w_eng_data;

    logic              w_ce;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [3:0]        w_sel;
    logic [DATA_W-1:0] w_data;

    // 33-bit compare so a huge cks_off_i cannot wrap past the length check.
    assign w_arg_err = hdr_addr_i[0] | hdr_len_i[0] | cks_off_i[0] |
                       (hdr_len_i == 32'd0) |
                       (({1'b0, cks_off_i} + 33'd2) > {1'b0, hdr_len_i});

    assign w_field_word = r_field_addr & ~32'd3;
    assign w_field_sel  = r_field_addr[1] ? SEL_LO : SEL_HI;

    // Start stays low outside KICK/WAIT, which gives the engine the idle
    // cycle it needs to leave its done state between runs.
    assign w_eng_start = (r_state == FILL_KICK) || (r_state == FILL_WAIT);

    cksum_fill_cksum u_cksum (
        .clk         (clk),
        .rst         (~rst),
        .i_start     (w_eng_start),
        .i_addr      (r_hdr_addr),
        .i_len       (r_hdr_len),
        .o_ready     (w_eng_ready),
        .o_cksum     (w_eng_cksum),
        .o_sram_ce   (w_eng_ce),
        .o_sram_we   (w_eng_we),
        .o_sram_addr (w_eng_addr),
        .o_sram_sel  (w_eng_sel),
        .o_sram_data (w_eng_data),
        .i_sram_data (sram.sram_data_i)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL_IDLE: begin
                if (start_i) begin
                    if (w_arg_err)   w_state_next = FILL_DONE;
                    else if (mode_i) w_state_next = FILL_KICK;
                    else             w_state_next = FILL_CLEAR;
                end
            end
            FILL_CLEAR: w_state_next = FILL_KICK;
            // Engine ready is not looked at in KICK: it may still be high
            // from the previous run.
            FILL_KICK:  w_state_next = FILL_WAIT;
            FILL_WAIT: begin
                if (w_eng_ready) w_state_next = r_mode ? FILL_DONE : FILL_WRITE;
            end
            FILL_WRITE: w_state_next = FILL_DONE;
            FILL_DONE:  if (!start_i) w_state_next = FILL_IDLE;
            default:    w_state_next = FILL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= FILL_IDLE;
            r_mode       <= 1'b0;
            r_hdr_addr   <= '0;
            r_hdr_len    <= '0;
            r_field_addr <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_ok         <= 1'b0;
            r_cksum      <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                FILL_IDLE: begin
                    if (start_i) begin
                        r_mode       <= mode_i;
                        r_hdr_addr   <= hdr_addr_i;
                        r_hdr_len    <= hdr_len_i;
                        r_field_addr <= hdr_addr_i + cks_off_i;
                        if (w_arg_err) begin
                            r_err  <= 1'b1;
                            r_done <= 1'b1;
                        end
                    end
                end
                FILL_WAIT: begin
                    if (w_eng_ready) begin
                        r_cksum <= w_eng_cksum;
                        if (r_mode) begin
                            r_ok   <= (w_eng_cksum == 16'h0000);
                            r_done <= 1'b1;
                        end
                    end
                end
                FILL_WRITE: r_done <= 1'b1;
                FILL_DONE: begin
                    if (!start_i) begin
                        r_done <= 1'b0;
                        r_err  <= 1'b0;
                        r_ok   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Port ownership is decided purely by state, so the two masters never
    // overlap and reset forces the port idle immediately.
    always_comb begin
        w_ce   = 1'b0;
        w_we   = 1'b0;
        w_addr = '0;
        w_sel  = '0;
        w_data = '0;
        case (r_state)
            FILL_CLEAR: begin
                w_ce   = 1'b1;
                w_we   = 1'b1;
                w_addr = w_field_word;
                w_sel  = w_field_sel;
            end
            FILL_WRITE: begin
                w_ce   = 1'b1;
                w_we   = 1'b1;
                w_addr = w_field_word;
                w_sel  = w_field_sel;
                w_data = r_field_addr[1] ? {16'h0000, r_cksum} : {r_cksum, 16'h0000};
            end
            FILL_KICK, FILL_WAIT: begin
                w_ce   = w_eng_ce;
                w_we   = w_eng_we;
                w_addr = w_eng_addr;
                w_sel  = w_eng_sel;
                w_data = w_eng_data;
            end
            default: ;
        endcase
    end

    assign sram.sram_ce_o   = w_ce;
    assign sram.sram_we_o   = w_we;
    assign sram.sram_addr_o = w_addr;
    assign sram.sram_sel_o  = w_sel;
    assign sram.sram_data_o = w_data;

    assign done_o  = r_done;
    assign err_o   = r_err;
    assign ok_o    = r_ok;
    assign cksum_o = r_cksum;

endmodule

// File: tb/tb_cksum_fill.sv
// Testbench for cksum_fill: word SRAM model with a write log, a table of
// directed operations, and hand-written sequences for corruption,
// back-to-back runs and asynchronous reset during the engine pass.
module tb_cksum_fill;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        mode_i;
    logic [31:0] hdr_addr_i;
    logic [31:0] hdr_len_i;
    logic [31:0] cks_off_i;
    logic        done_o;
    logic        err_o;
    logic        ok_o;
    logic [15:0] cksum_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cur_op  = 0;

    always #5 clk = ~clk;

    cksum_fill_if bus();

    cksum_fill dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .hdr_addr_i (hdr_addr_i),
        .hdr_len_i  (hdr_len_i),
        .cks_off_i  (cks_off_i),
        .sram       (bus),
        .done_o     (done_o),
        .err_o      (err_o),
        .ok_o       (ok_o),
        .cksum_o    (cksum_o)
    );

    // ---------------- SRAM model (1 KiB, byte lane 3 = lowest address) ----
    typedef struct {
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
    } wr_t;

    logic [31:0] mem [0:255];
    wr_t         wr_q [$];

    always @(posedge clk) begin
        if (bus.sram_ce_o) begin
            if (bus.sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.sram_sel_o[b])
                        mem[bus.sram_addr_o[9:2]][8*b +: 8] <= bus.sram_data_o[8*b +: 8];
                wr_q.push_back('{bus.sram_addr_o, bus.sram_sel_o, bus.sram_data_o});
            end else begin
                bus.sram_data_i <= mem[bus.sram_addr_o[9:2]];
            end
        end
    end

    // ---------------- helpers ---------------------------------------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL op%0d %s: got %h expected %h", cur_op, nm, got, exp);
        end
    endtask

    typedef struct {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] len;
        logic [31:0] off;
        logic        exp_err;
        logic        exp_ok;
        logic        chk_cks;
        logic [15:0] exp_cks;
        int          nwr;
        logic [31:0] waddr;
        logic [3:0]  wsel;
        logic [31:0] wdata;
    } vec_t;

    // Runs one operation and checks it. Leaves start_i low for exactly one
    // rising edge before returning, so consecutive calls are back-to-back.
    task automatic apply(input vec_t v);
        int cyc;
        int ces;
        bit tmo;
        wr_q.delete();
        mode_i     = v.mode;
        hdr_addr_i = v.addr;
        hdr_len_i  = v.len;
        cks_off_i  = v.off;
        start_i    = 1'b1;
        cyc = 0;
        ces = 0;
        tmo = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (bus.sram_ce_o) ces++;
            if (done_o) break;
            if (cyc > 500) begin
                tmo = 1'b1;
                break;
            end
        end
        chk("timeout", {31'd0, tmo}, 32'd0);
        chk("err_o", {31'd0, err_o}, {31'd0, v.exp_err});
        chk("ok_o", {31'd0, ok_o}, {31'd0, v.exp_ok});
        if (v.chk_cks) chk("cksum_o", {16'd0, cksum_o}, {16'd0, v.exp_cks});
        chk("n_writes", wr_q.size(), v.nwr);
        if (v.nwr == 2 && wr_q.size() == 2) begin
            chk("clear_addr", wr_q[0].a, v.waddr);
            chk("clear_sel", {28'd0, wr_q[0].s}, {28'd0, v.wsel});
            chk("clear_data", wr_q[0].d, 32'd0);
            chk("write_addr", wr_q[1].a, v.waddr);
            chk("write_sel", {28'd0, wr_q[1].s}, {28'd0, v.wsel});
            chk("write_data", wr_q[1].d, v.wdata);
        end
        if (v.exp_err) begin
            chk("err_latency_le2", {31'd0, (cyc <= 2)}, 32'd1);
            chk("err_sram_ce_cycles", ces, 0);
        end
        $display("[TB] op%0d mode=%0d addr=%h len=%0d off=%0d -> err=%0d ok=%0d cksum=%h writes=%0d cycles=%0d",
                 cur_op, v.mode, v.addr, v.len, v.off, err_o, ok_o, cksum_o, wr_q.size(), cyc);
        start_i = 1'b0;
        @(negedge clk);
        chk("done_dropped", {29'd0, done_o, err_o, ok_o}, 32'd0);
        cur_op++;
    endtask

    // ---------------- watchdog --------------------------------------------
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main test -------------------------------------------
    vec_t vecs [8];

    initial begin
        int wait_cnt;

        vecs[0] = '{1'b0, 32'h100, 32'd20, 32'd10, 1'b0, 1'b0, 1'b1, 16'hB861, 2, 32'h108, 4'b0011, 32'h0000B861};
        vecs[1] = '{1'b1, 32'h100, 32'd20, 32'd10, 1'b0, 1'b1, 1'b1, 16'h0000, 0, 32'h0, 4'b0000, 32'h0};
        vecs[2] = '{1'b0, 32'h200, 32'd20, 32'd8,  1'b0, 1'b0, 1'b1, 16'hB861, 2, 32'h208, 4'b1100, 32'hB8610000};
        vecs[3] = '{1'b1, 32'h200, 32'd20, 32'd8,  1'b0, 1'b1, 1'b1, 16'h0000, 0, 32'h0, 4'b0000, 32'h0};
        vecs[4] = '{1'b0, 32'h100, 32'd20, 32'd19, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 32'h0, 4'b0000, 32'h0};
        vecs[5] = '{1'b0, 32'h100, 32'd0,  32'd10, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 32'h0, 4'b0000, 32'h0};
        vecs[6] = '{1'b1, 32'h100, 32'd20, 32'd20, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 32'h0, 4'b0000, 32'h0};
        vecs[7] = '{1'b0, 32'h101, 32'd20, 32'd10, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 32'h0, 4'b0000, 32'h0};

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        // IPv4 header at 0x100, field at offset 10 holds junk.
        mem[8'h40] = 32'h45000073;
        mem[8'h41] = 32'h00004000;
        mem[8'h42] = 32'h4011FFFF;
        mem[8'h43] = 32'hC0A80001;
        mem[8'h44] = 32'hC0A800C7;
        // Same halfwords at 0x200, with the junk field moved to offset 8.
        mem[8'h80] = 32'h45000073;
        mem[8'h81] = 32'h00004000;
        mem[8'h82] = 32'hFFFF4011;
        mem[8'h83] = 32'hC0A80001;
        mem[8'h84] = 32'hC0A800C7;

        start_i    = 1'b0;
        mode_i     = 1'b0;
        hdr_addr_i = 32'h0;
        hdr_len_i  = 32'h0;
        cks_off_i  = 32'h0;
        rst        = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {28'd0, done_o, err_o, ok_o, bus.sram_ce_o}, 32'd0);
        chk("reset_cksum", {16'd0, cksum_o}, 32'd0);
        chk("reset_sram_bus", {bus.sram_we_o, bus.sram_sel_o} | bus.sram_addr_o | bus.sram_data_o, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) apply(vecs[i]);

        chk("mem_field_0x108", mem[8'h42], 32'h4011B861);
        chk("mem_field_0x208", mem[8'h82], 32'hB8614011);

        // Corrupt byte 0x10F (0x01 -> 0x02): verify must reject.
        mem[8'h43] = 32'hC0A80002;
        apply('{1'b1, 32'h100, 32'd20, 32'd10, 1'b0, 1'b0, 1'b1, 16'hFFFE, 0, 32'h0, 4'b0000, 32'h0});

        // Regenerate, then verify back-to-back (start_i low for one cycle).
        apply('{1'b0, 32'h100, 32'd20, 32'd10, 1'b0, 1'b0, 1'b1, 16'hB860, 2, 32'h108, 4'b0011, 32'h0000B860});
        apply('{1'b1, 32'h100, 32'd20, 32'd10, 1'b0, 1'b1, 1'b1, 16'h0000, 0, 32'h0, 4'b0000, 32'h0});

        // Asynchronous reset while the engine is reading (WAIT).
        mode_i     = 1'b0;
        hdr_addr_i = 32'h200;
        hdr_len_i  = 32'd20;
        cks_off_i  = 32'd8;
        start_i    = 1'b1;
        wait_cnt   = 0;
        while (!(bus.sram_ce_o && !bus.sram_we_o) && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("reach_wait", {31'd0, (wait_cnt < 50)}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_outputs", {28'd0, done_o, err_o, ok_o, bus.sram_ce_o}, 32'd0);
        chk("async_rst_cksum", {16'd0, cksum_o}, 32'd0);
        chk("async_rst_sram_bus", {bus.sram_we_o, bus.sram_sel_o} | bus.sram_addr_o | bus.sram_data_o, 32'd0);
        $display("[TB] op%0d async reset during engine pass -> done=%0d ce=%0d cksum=%h",
                 cur_op, done_o, bus.sram_ce_o, cksum_o);
        cur_op++;
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        apply('{1'b0, 32'h200, 32'd20, 32'd8, 1'b0, 1'b0, 1'b1, 16'hB861, 2, 32'h208, 4'b1100, 32'hB8610000});
        apply('{1'b1, 32'h200, 32'd20, 32'd8, 1'b0, 1'b1, 1'b1, 16'h0000, 0, 32'h0, 4'b0000, 32'h0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cksum_fill.md
Name: cksum_fill

Overview:
- Controller directly downstream of the checksum engine; turns a raw 16-bit one's-complement sum into a finished header in SRAM.
- Generate mode: zeroes the checksum field in SRAM, runs the engine over the header, then writes the result back into the field.
- Verify mode: runs the engine over the header unchanged and reports whether the header is valid (result == 0).
- Instantiates the existing cksum engine and arbitrates the single SRAM master port between itself and the engine.

Parameters:
- none; widths come from `ADDR_BUS / `DATA_BUS (32 bit) in def.v.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start_i  in  1  level request; held high until done_o, then dropped
- mode_i  in  1  0 = generate, 1 = verify; sampled in IDLE with start_i
- hdr_addr_i  in  32  header start byte address; must be even
- hdr_len_i  in  32  header length in bytes; must be even and nonzero
- cks_off_i  in  32  byte offset of the checksum field inside the header; must be even
- sram_ce_o  out  1  SRAM chip enable
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  32  SRAM byte address
- sram_sel_o  out  4  SRAM byte enables
- sram_data_o  out  32  SRAM write data
- sram_data_i  in  32  SRAM read data, valid one cycle after the address
- done_o  out  1  operation finished; held high until start_i drops
- err_o  out  1  bad arguments; valid while done_o is high
- ok_o  out  1  verify mode: header checksum valid; valid while done_o is high
- cksum_o  out  16  engine result; valid while done_o is high

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - All outputs 0: sram_*, done_o, err_o, ok_o, cksum_o.
  - Internal cksum instance is reset through its synchronous active-high rst, driven by ~rst.
  - Reset mid-operation abandons the run. A partially cleared field stays in SRAM; no recovery is attempted.
- Latched on start in IDLE: mode, hdr_addr, hdr_len, and field_addr = hdr_addr_i + cks_off_i.
- Argument error, checked in IDLE: any of hdr_addr_i[0], hdr_len_i[0], cks_off_i[0] set, hdr_len_i == 0, or cks_off_i + 2 > hdr_len_i.
  - On error go straight to DONE with err_o = 1. No SRAM access is made.
- States:
  - IDLE:
    - start_i && error -> DONE.
    - start_i && mode == 0 -> CLEAR.
    - start_i && mode == 1 -> KICK.
  - CLEAR (1 cycle):
    - Drive ce = 1, we = 1, addr = {field_addr[31:2], 2'b00}, data = 0.
    - sel = 4'b1100 if field_addr[1] == 0, else 4'b0011.
    - -> KICK.
  - KICK (1 cycle):
    - Assert the engine's start; engine address = hdr_addr, engine length = hdr_len.
    - The engine's ready output is ignored here, because it may still be high from the previous run.
    - -> WAIT.
  - WAIT:
    - Engine start stays high; the engine's SRAM port is passed through to sram_*.
    - On engine ready: latch its 16-bit value into cksum_o and drop engine start.
    - Generate mode -> WRITE. Verify mode -> DONE with ok_o = (value == 16'h0000).
  - WRITE (1 cycle):
    - Same addr and sel as CLEAR, we = 1.
    - data = {cksum_o, 16'h0} if field_addr[1] == 0, else {16'h0, cksum_o}.
    - -> DONE.
  - DONE:
    - done_o = 1; sram_ce_o = 0.
    - If !start_i: clear done_o, err_o and ok_o, then -> IDLE. cksum_o is held.
- SRAM mux:
  - CLEAR / WRITE: the block drives the port.
  - KICK / WAIT: the engine drives the port.
  - Otherwise: ce = 0, we = 0, other fields 0.
  - sram_*_o are combinational from state and registers. There is no cycle in which both masters drive.
- Latency:
  - Generate = engine time + 4 cycles after start: CLEAR, KICK, WRITE, and the DONE entry.
  - Verify = engine time + 2 cycles.
- Halfword packing: a halfword at address%4 == 0 sits in data[31:16]; at address%4 == 2 it sits in data[15:0]. This matches the engine's summing order.
- Engine handshake: the engine returns to its free state only once its start is low. The block guarantees start is low for at least one cycle between runs, because DONE -> IDLE -> KICK spans at least 2 cycles.
- start_i dropping before DONE is ignored; the run completes.

Decomposition:
- State encodings (FILL_IDLE … FILL_DONE) and the select constants SEL_HI = 4'b1100, SEL_LO = 4'b0011 go in the shared def.v.
- One sub-module: the existing cksum engine, instantiated as u_cksum.
- All other logic is flat: one FSM block plus a combinational SRAM mux.

Test Plan:
- Generate, 20-byte IPv4 header at 0x100.
  - Stimulus: header bytes 45 00 00 73 00 00 40 00 40 11 XX XX c0 a8 00 01 c0 a8 00 c7; cks_off_i = 10, with junk 0xFFFF in the field.
  - Response: CLEAR writes addr 0x108, sel 0011, data 0; WRITE writes addr 0x108, sel 0011, data 0x0000B861; cksum_o = 0xB861; err_o = 0.
- Verify the same header after generate -> ok_o = 1, cksum_o = 0x0000. Corrupt byte 0x10F to 0x02, then verify again -> ok_o = 0.
- Field at an aligned address (cks_off_i = 8, header at 0x200) -> both writes use sel 1100 at addr 0x208; written data has the checksum in [31:16].
- Bad arguments (cks_off_i = 19, hdr_len_i = 20; separately hdr_len_i = 0) -> done_o within 2 cycles, err_o = 1, no cycle with sram_ce_o = 1.
- Back-to-back runs with start_i low for exactly 1 cycle between them -> second run correct; the stale engine ready is not sampled in KICK.
- rst pulled low during WAIT -> all outputs 0 immediately (asynchronously); a fresh run afterwards completes correctly.
